// File: rtl/turn_ctrl_pkg.sv
// Shared types and constants for the two-player round sequencer.
package turn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AIM,
    FLIGHT,
    RESOLVE,
    SWITCH,
    OVER
  } state_t;

  localparam logic PLAYER0 = 1'b0;
  localparam logic PLAYER1 = 1'b1;

  localparam int HP_W    = 3;
  localparam int TIMER_W = 29;

  localparam int AIM_TIMEOUT_DEF    = 400_000_000;
  localparam int FLIGHT_TIMEOUT_DEF = 200_000_000;
  localparam int SWITCH_DELAY_DEF   = 20_000_000;

  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

endpackage

// File: rtl/turn_ctrl_timer.sv
// Free-running cycle counter with synchronous clear; done flags count==limit.
// The limit is a port so one counter can serve every timed state.
module cycle_timer #(
  parameter int W = 29
) (
  input  logic         clk40MHz,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk40MHz) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/turn_ctrl.sv
// Round sequencer: aim, launch, flight, resolve hit into HP, pause, alternate turns.
// Launch follows the throw_flag rise by 1 cycle; end_throw follows land by 1 cycle.
module turn_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int HP_INIT        = 5,
  parameter int AIM_TIMEOUT    = AIM_TIMEOUT_DEF,
  parameter int FLIGHT_TIMEOUT = FLIGHT_TIMEOUT_DEF,
  parameter int SWITCH_DELAY   = SWITCH_DELAY_DEF
) (
  input  logic       clk40MHz,
  input  logic       rst,
  input  logic       start,
  input  logic       throw_flag,
  input  logic [4:0] power,
  input  logic       hit,
  input  logic       land,
  output logic       turn,
  output logic       end_throw,
  output logic       launch,
  output logic [4:0] launch_power,
  output logic [2:0] hp0,
  output logic [2:0] hp1,
  output logic       game_over,
  output logic       winner
);

  localparam logic [TIMER_W-1:0] AIM_LIM    = TIMER_W'(AIM_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] FLIGHT_LIM = TIMER_W'(FLIGHT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SWITCH_LIM = TIMER_W'(SWITCH_DELAY - 1);
  localparam logic [HP_W-1:0]    HP_START   = HP_W'(HP_INIT);

  state_t             state;
  logic               throw_flag_d;
  logic               hit_reg;
  logic               rise;
  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_done;
  logic [TIMER_W-1:0] tmr_limit;
  logic [HP_W-1:0]    opp_hp_next;

  assign rise        = throw_flag & ~throw_flag_d;
  assign tmr_en      = (state == AIM) || (state == FLIGHT) || (state == SWITCH);
  assign opp_hp_next = hp_dec((turn == PLAYER0) ? hp1 : hp0);

  always_comb begin
    tmr_limit = '0;
    case (state)
      AIM:     tmr_limit = AIM_LIM;
      FLIGHT:  tmr_limit = FLIGHT_LIM;
      SWITCH:  tmr_limit = SWITCH_LIM;
      default: tmr_limit = '0;
    endcase
  end

  // Clear the shared timer on exactly the cycles the FSM below changes state.
  always_comb begin
    tmr_clr = 1'b0;
    case (state)
      IDLE:    tmr_clr = start;
      AIM:     tmr_clr = rise | tmr_done;
      FLIGHT:  tmr_clr = land | tmr_done;
      RESOLVE: tmr_clr = 1'b1;
      SWITCH:  tmr_clr = tmr_done;
      OVER:    tmr_clr = start;
      default: tmr_clr = 1'b1;
    endcase
  end

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .limit    (tmr_limit),
    .done     (tmr_done)
  );

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state        <= IDLE;
      turn         <= PLAYER0;
      end_throw    <= 1'b0;
      launch       <= 1'b0;
      launch_power <= '0;
      hp0          <= HP_START;
      hp1          <= HP_START;
      game_over    <= 1'b0;
      winner       <= 1'b0;
      hit_reg      <= 1'b0;
      throw_flag_d <= 1'b0;
    end else begin
      throw_flag_d <= throw_flag;
      launch       <= 1'b0;
      end_throw    <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= AIM;
            turn      <= PLAYER0;
            hp0       <= HP_START;
            hp1       <= HP_START;
            game_over <= 1'b0;
          end
        end
        AIM: begin
          // A throw edge on the timeout cycle still launches.
          if (rise) begin
            state        <= FLIGHT;
            launch       <= 1'b1;
            launch_power <= power;
            hit_reg      <= 1'b0;
          end else if (tmr_done) begin
            state <= SWITCH;
          end
        end
        FLIGHT: begin
          if (hit) begin
            hit_reg <= 1'b1;
          end
          if (land || tmr_done) begin
            state     <= RESOLVE;
            end_throw <= 1'b1;
          end
        end
        RESOLVE: begin
          if (hit_reg) begin
            if (turn == PLAYER0) begin
              hp1 <= opp_hp_next;
            end else begin
              hp0 <= opp_hp_next;
            end
          end
          if (hit_reg && (opp_hp_next == '0)) begin
            state     <= OVER;
            winner    <= turn;
            game_over <= 1'b1;
          end else begin
            state <= SWITCH;
          end
        end
        SWITCH: begin
          if (tmr_done) begin
            turn  <= ~turn;
            state <= AIM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_ctrl.sv
// Scenario bench for turn_ctrl with short timeouts and a randomized game loop.
module tb_turn_ctrl;

  localparam int HPI = 2;
  localparam int AT  = 20;
  localparam int FT  = 15;
  localparam int SD  = 4;

  logic       clk40MHz = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       throw_flag = 1'b0;
  logic [4:0] power = '0;
  logic       hit = 1'b0;
  logic       land = 1'b0;
  logic       turn, end_throw, launch, game_over, winner;
  logic [4:0] launch_power;
  logic [2:0] hp0, hp1;

  int total = 0;
  int bad = 0;

  turn_ctrl #(
    .HP_INIT(HPI), .AIM_TIMEOUT(AT), .FLIGHT_TIMEOUT(FT), .SWITCH_DELAY(SD)
  ) dut (
    .clk40MHz(clk40MHz), .rst(rst), .start(start), .throw_flag(throw_flag),
    .power(power), .hit(hit), .land(land), .turn(turn), .end_throw(end_throw),
    .launch(launch), .launch_power(launch_power), .hp0(hp0), .hp1(hp1),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk40MHz = ~clk40MHz;

  task automatic step();
    @(posedge clk40MHz);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fresh_game();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_start();
  endtask

  task automatic throw_it(input logic [4:0] p);
    throw_flag = 1'b1;
    power = p;
    step();
    throw_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total += 8;
    if (turn !== 1'b0) begin bad++; $display("FAIL reset_turn: got %0b want 0", turn); end
    if (end_throw !== 1'b0) begin bad++; $display("FAIL reset_end_throw: got %0b want 0", end_throw); end
    if (launch !== 1'b0) begin bad++; $display("FAIL reset_launch: got %0b want 0", launch); end
    if (launch_power !== 5'd0) begin bad++; $display("FAIL reset_lp: got %0d want 0", launch_power); end
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL reset_hp0: got %0d want %0d", hp0, HPI); end
    if (hp1 !== 3'(HPI)) begin bad++; $display("FAIL reset_hp1: got %0d want %0d", hp1, HPI); end
    if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
    if (winner !== 1'b0) begin bad++; $display("FAIL reset_winner: got %0b want 0", winner); end
    rst = 1'b0;
  endtask

  task automatic test_launch();
    pulse_start();
    repeat (3) step();
    throw_it(5'd17);
    total += 4;
    if (launch !== 1'b1) begin bad++; $display("FAIL launch_pulse: got %0b want 1", launch); end
    if (launch_power !== 5'd17) begin bad++; $display("FAIL launch_power: got %0d want 17", launch_power); end
    if (turn !== 1'b0) begin bad++; $display("FAIL launch_turn: got %0b want 0", turn); end
    step();
    if (launch !== 1'b0) begin bad++; $display("FAIL launch_width: got %0b want 0", launch); end
  endtask

  // Continues the flight started by test_launch.
  task automatic test_hit_land();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    step();
    land = 1'b1;
    step();
    land = 1'b0;
    total += 6;
    if (end_throw !== 1'b1) begin bad++; $display("FAIL hl_end_throw: got %0b want 1", end_throw); end
    step();
    if (end_throw !== 1'b0) begin bad++; $display("FAIL hl_end_throw_width: got %0b want 0", end_throw); end
    if (hp1 !== 3'(HPI - 1)) begin bad++; $display("FAIL hl_hp1: got %0d want %0d", hp1, HPI - 1); end
    repeat (SD - 1) step();
    if (turn !== 1'b0) begin bad++; $display("FAIL hl_turn_early: got %0b want 0", turn); end
    step();
    if (turn !== 1'b1) begin bad++; $display("FAIL hl_turn_toggle: got %0b want 1", turn); end
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL hl_hp0: got %0d want %0d", hp0, HPI); end
  endtask

  // Player 1 is now aiming; let the aim window expire.
  task automatic test_aim_timeout();
    logic saw = 1'b0;
    repeat (AT + SD - 1) begin
      step();
      if (launch || end_throw) saw = 1'b1;
    end
    total += 5;
    if (turn !== 1'b1) begin bad++; $display("FAIL at_turn_early: got %0b want 1", turn); end
    step();
    if (turn !== 1'b0) begin bad++; $display("FAIL at_turn_toggle: got %0b want 0", turn); end
    if (saw !== 1'b0) begin bad++; $display("FAIL at_spurious_pulse: got %0b want 0", saw); end
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL at_hp0: got %0d want %0d", hp0, HPI); end
    if (hp1 !== 3'(HPI - 1)) begin bad++; $display("FAIL at_hp1: got %0d want %0d", hp1, HPI - 1); end
  endtask

  task automatic test_same_cycle();
    fresh_game();
    throw_it(5'd3);
    step();
    hit = 1'b1;
    land = 1'b1;
    step();
    hit = 1'b0;
    land = 1'b0;
    total += 2;
    if (end_throw !== 1'b1) begin bad++; $display("FAIL sc_end_throw: got %0b want 1", end_throw); end
    step();
    if (hp1 !== 3'(HPI - 1)) begin bad++; $display("FAIL sc_hp1: got %0d want %0d", hp1, HPI - 1); end
  endtask

  task automatic test_miss();
    fresh_game();
    hit = 1'b1;
    land = 1'b1;
    step();
    hit = 1'b0;
    land = 1'b0;
    total += 6;
    if (end_throw !== 1'b0) begin bad++; $display("FAIL miss_stray_land: got %0b want 0", end_throw); end
    throw_it(5'd9);
    if (launch !== 1'b1) begin bad++; $display("FAIL miss_launch: got %0b want 1", launch); end
    step();
    step();
    land = 1'b1;
    step();
    land = 1'b0;
    if (end_throw !== 1'b1) begin bad++; $display("FAIL miss_end_throw: got %0b want 1", end_throw); end
    step();
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL miss_hp0: got %0d want %0d", hp0, HPI); end
    if (hp1 !== 3'(HPI)) begin bad++; $display("FAIL miss_hp1: got %0d want %0d", hp1, HPI); end
    if (game_over !== 1'b0) begin bad++; $display("FAIL miss_game_over: got %0b want 0", game_over); end
  endtask

  task automatic test_flight_timeout();
    logic saw = 1'b0;
    fresh_game();
    throw_it(5'd31);
    hit = 1'b1;
    step();
    hit = 1'b0;
    repeat (FT - 2) begin
      step();
      if (end_throw) saw = 1'b1;
    end
    total += 3;
    if (saw !== 1'b0) begin bad++; $display("FAIL ft_early_end: got %0b want 0", saw); end
    step();
    if (end_throw !== 1'b1) begin bad++; $display("FAIL ft_end_throw: got %0b want 1", end_throw); end
    step();
    if (hp1 !== 3'(HPI - 1)) begin bad++; $display("FAIL ft_sticky_hit: got %0d want %0d", hp1, HPI - 1); end
  endtask

  task automatic test_game_over();
    logic saw = 1'b0;
    fresh_game();
    throw_it(5'd10);
    step();
    hit = 1'b1;
    land = 1'b1;
    step();
    hit = 1'b0;
    land = 1'b0;
    repeat (SD + 1) step();
    repeat (AT + SD) step();
    throw_it(5'd11);
    hit = 1'b1;
    land = 1'b1;
    step();
    hit = 1'b0;
    land = 1'b0;
    step();
    total += 12;
    if (game_over !== 1'b1) begin bad++; $display("FAIL go_game_over: got %0b want 1", game_over); end
    if (winner !== 1'b0) begin bad++; $display("FAIL go_winner: got %0b want 0", winner); end
    if (hp1 !== 3'd0) begin bad++; $display("FAIL go_hp1: got %0d want 0", hp1); end
    throw_flag = 1'b1;
    repeat (6) begin
      step();
      if (launch || end_throw) saw = 1'b1;
    end
    throw_flag = 1'b0;
    if (saw !== 1'b0) begin bad++; $display("FAIL go_held_pulse: got %0b want 0", saw); end
    if (game_over !== 1'b1) begin bad++; $display("FAIL go_held: got %0b want 1", game_over); end
    if (turn !== 1'b0) begin bad++; $display("FAIL go_turn_held: got %0b want 0", turn); end
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL go_hp0: got %0d want %0d", hp0, HPI); end
    pulse_start();
    if (hp0 !== 3'(HPI)) begin bad++; $display("FAIL go_restart_hp0: got %0d want %0d", hp0, HPI); end
    if (hp1 !== 3'(HPI)) begin bad++; $display("FAIL go_restart_hp1: got %0d want %0d", hp1, HPI); end
    if (turn !== 1'b0) begin bad++; $display("FAIL go_restart_turn: got %0b want 0", turn); end
    if (game_over !== 1'b0) begin bad++; $display("FAIL go_restart_over: got %0b want 0", game_over); end
    if (winner !== 1'b0) begin bad++; $display("FAIL go_restart_winner: got %0b want 0", winner); end
  endtask

  task automatic test_reset_mid_flight();
    fresh_game();
    throw_it(5'd7);
    hit = 1'b1;
    land = 1'b1;
    step();
    hit = 1'b0;
    land = 1'b0;
    repeat (SD + 1) step();
    throw_it(5'd22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total += 6;
    if (launch !== 1'b0) begin bad++; $display("FAIL rm_launch: got %0b want 0", launch); end
    if (launch_power !== 5'd0) begin bad++; $display("FAIL rm_lp: got %0d want 0", launch_power); end
    if (turn !== 1'b0) begin bad++; $display("FAIL rm_turn: got %0b want 0", turn); end
    if (hp1 !== 3'(HPI)) begin bad++; $display("FAIL rm_hp1: got %0d want %0d", hp1, HPI); end
    if (end_throw !== 1'b0) begin bad++; $display("FAIL rm_end_throw: got %0b want 0", end_throw); end
    if (game_over !== 1'b0) begin bad++; $display("FAIL rm_game_over: got %0b want 0", game_over); end
  endtask

  task automatic test_held_flag();
    logic saw = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    throw_flag = 1'b1;
    pulse_start();
    repeat (5) begin
      step();
      if (launch) saw = 1'b1;
    end
    throw_flag = 1'b0;
    step();
    total += 3;
    if (saw !== 1'b0) begin bad++; $display("FAIL hf_no_launch: got %0b want 0", saw); end
    throw_it(5'd9);
    if (launch !== 1'b1) begin bad++; $display("FAIL hf_launch: got %0b want 1", launch); end
    if (launch_power !== 5'd9) begin bad++; $display("FAIL hf_lp: got %0d want 9", launch_power); end
  endtask

  // Randomized turns checked against a per-player HP model.
  task automatic test_random();
    int   m_hp[2];
    logic m_turn;
    logic m_over;
    logic saw;
    logic to, do_hit;
    logic [4:0] p;
    int   a, n, m;
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_start();
    m_hp[0] = HPI;
    m_hp[1] = HPI;
    m_turn = 1'b0;
    for (int t = 0; t < 60; t++) begin
      saw = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        repeat (AT + SD - 1) begin
          step();
          if (launch || end_throw) saw = 1'b1;
        end
        step();
        total += 2;
        if (turn !== !m_turn) begin bad++; $display("FAIL rnd_forfeit_turn: got %0b want %0b", turn, !m_turn); end
        if (saw !== 1'b0) begin bad++; $display("FAIL rnd_forfeit_pulse: got %0b want 0", saw); end
        m_turn = !m_turn;
        continue;
      end
      a = $urandom_range(0, AT - 1);
      for (int i = 0; i < a; i++) begin
        if (i == 0 && $urandom_range(0, 1) == 1) begin
          hit = 1'b1;
          land = 1'b1;
        end
        step();
        hit = 1'b0;
        land = 1'b0;
        if (launch || end_throw) saw = 1'b1;
      end
      p = 5'($urandom);
      throw_it(p);
      total += 3;
      if (launch !== 1'b1) begin bad++; $display("FAIL rnd_launch: got %0b want 1 (aim %0d)", launch, a); end
      if (launch_power !== p) begin bad++; $display("FAIL rnd_lp: got %0d want %0d", launch_power, p); end
      to = ($urandom_range(0, 4) == 0);
      n = to ? FT - 1 : $urandom_range(0, FT - 1);
      do_hit = 1'($urandom);
      m = $urandom_range(0, n);
      for (int k = 0; k <= n; k++) begin
        hit = do_hit && (k == m);
        land = !to && (k == n);
        step();
        hit = 1'b0;
        land = 1'b0;
        if (launch || (k < n && end_throw)) saw = 1'b1;
      end
      if (end_throw !== 1'b1) begin bad++; $display("FAIL rnd_end_throw: got %0b want 1", end_throw); end
      if (do_hit) begin
        m_hp[!m_turn] = m_hp[!m_turn] - 1;
      end
      m_over = do_hit && (m_hp[!m_turn] == 0);
      step();
      total += 4;
      if (saw !== 1'b0) begin bad++; $display("FAIL rnd_stray_pulse: got %0b want 0", saw); end
      if (hp0 !== 3'(m_hp[0])) begin bad++; $display("FAIL rnd_hp0: got %0d want %0d", hp0, m_hp[0]); end
      if (hp1 !== 3'(m_hp[1])) begin bad++; $display("FAIL rnd_hp1: got %0d want %0d", hp1, m_hp[1]); end
      if (game_over !== m_over) begin bad++; $display("FAIL rnd_game_over: got %0b want %0b", game_over, m_over); end
      if (m_over) begin
        total += 2;
        if (winner !== m_turn) begin bad++; $display("FAIL rnd_winner: got %0b want %0b", winner, m_turn); end
        pulse_start();
        m_hp[0] = HPI;
        m_hp[1] = HPI;
        m_turn = 1'b0;
        if (turn !== 1'b0) begin bad++; $display("FAIL rnd_restart_turn: got %0b want 0", turn); end
      end else begin
        repeat (SD - 1) step();
        total += 2;
        if (turn !== m_turn) begin bad++; $display("FAIL rnd_turn_hold: got %0b want %0b", turn, m_turn); end
        step();
        if (turn !== !m_turn) begin bad++; $display("FAIL rnd_turn_toggle: got %0b want %0b", turn, !m_turn); end
        m_turn = !m_turn;
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_hit_land();
    test_aim_timeout();
    test_same_cycle();
    test_miss();
    test_flight_timeout();
    test_game_over();
    test_reset_mid_flight();
    test_held_flag();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
